// File: rtl/macc_if.sv
// macc_if: operand/result bundle for macc_unit.
//   i_data_a, i_data_b : packed signed 8-bit operands, element k at [8k+7:8k]
//   i_valid            : operand vector valid this cycle
//   o_data             : signed dot-product result, OUTPUT_DATA_WIDTH bits
//   o_valid            : o_data holds a valid result
// Modports: master = operand source / result sink, slave = macc_unit.
interface macc_if #(
  parameter int NUM_INPUTS = 8
);
  localparam int unsigned ADDER_LAYERS      = $clog2(NUM_INPUTS);
  localparam int unsigned OUTPUT_DATA_WIDTH = 16 + ADDER_LAYERS;

  logic [8*NUM_INPUTS-1:0]      i_data_a;
  logic [8*NUM_INPUTS-1:0]      i_data_b;
  logic                         i_valid;
  logic [OUTPUT_DATA_WIDTH-1:0] o_data;
  logic                         o_valid;

  modport master (
    output i_data_a, i_data_b, i_valid,
    input  o_data, o_valid
  );

  modport slave (
    input  i_data_a, i_data_b, i_valid,
    output o_data, o_valid
  );
endinterface

// File: rtl/macc_unit.sv
// macc_unit: pipelined signed multiply-accumulate (dot product).
//   NUM_INPUTS pairs of signed 8-bit operands are multiplied (stage 0) and
//   summed through a registered binary adder tree of $clog2(NUM_INPUTS)
//   layers. Latency 1 + ADDER_LAYERS cycles, one vector per cycle, no
//   back-pressure.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every pipeline register
//   bus    : macc_if.slave (i_data_a, i_data_b, i_valid, o_data, o_valid)
// Build option:
//   MACC_DATA_GATE_EN : when defined, each stage's data registers load only
//                       when that stage's incoming valid bit is set, so
//                       o_data holds the last result while o_valid is low.
module macc_unit #(
  parameter int NUM_INPUTS = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  macc_if.slave bus
);
  localparam int unsigned ADDER_LAYERS      = $clog2(NUM_INPUTS);
  localparam int unsigned OUTPUT_DATA_WIDTH = 16 + ADDER_LAYERS;

`ifdef MACC_DATA_GATE_EN
  localparam bit DATA_GATE = 1'b1;
`else
  localparam bit DATA_GATE = 1'b0;
`endif

  // Number of nodes in tree layer l (layer 0 = products).
  function automatic int unsigned nodes_at(input int unsigned l);
    int unsigned n;
    n = NUM_INPUTS;
    for (int unsigned i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Bit offset of layer l inside the flat tree register; layer i nodes are
  // 16+i bits wide.
  function automatic int unsigned base_at(input int unsigned l);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < l; i++) b += nodes_at(i) * (16 + i);
    return b;
  endfunction

  localparam int unsigned TREE_BITS = base_at(ADDER_LAYERS + 1);
  localparam int unsigned OUT_BASE  = base_at(ADDER_LAYERS);

  // All layers packed into one vector so each layer can keep its exact
  // width; every node reads only fixed slices of the layer before it.
  logic [TREE_BITS-1:0]  tree_q;
  logic [ADDER_LAYERS:0] vld_q;
  logic [ADDER_LAYERS:0] stage_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= bus.i_valid;
      for (int unsigned i = 1; i <= ADDER_LAYERS; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  for (genvar l = 0; l <= ADDER_LAYERS; l++) begin : g_layer
    localparam int unsigned W  = 16 + l;
    localparam int unsigned NN = nodes_at(l);
    localparam int unsigned B  = base_at(l);

    if (l == 0) begin : g_en0
      assign stage_en[l] = ~DATA_GATE | bus.i_valid;
    end else begin : g_enl
      assign stage_en[l] = ~DATA_GATE | vld_q[l-1];
    end

    for (genvar k = 0; k < NN; k++) begin : g_node
      logic signed [W-1:0] node_d;

      if (l == 0) begin : g_mul
        logic signed [15:0] op_a;
        logic signed [15:0] op_b;
        assign op_a   = 16'($signed(bus.i_data_a[8*k +: 8]));
        assign op_b   = 16'($signed(bus.i_data_b[8*k +: 8]));
        // |product| <= 16384, so the low 16 bits are the exact result.
        assign node_d = op_a * op_b;
      end else begin : g_add
        localparam int unsigned PN = nodes_at(l - 1);
        localparam int unsigned PB = base_at(l - 1);
        localparam int unsigned PW = 15 + l;
        if (2*k + 1 < PN) begin : g_pair
          assign node_d = W'($signed(tree_q[PB + 2*k*PW +: PW]))
                        + W'($signed(tree_q[PB + (2*k+1)*PW +: PW]));
        end else begin : g_pass
          // Odd leftover: added to zero, i.e. sign-extended pass-through.
          assign node_d = W'($signed(tree_q[PB + 2*k*PW +: PW]));
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tree_q[B + k*W +: W] <= '0;
        end else if (stage_en[l]) begin
          tree_q[B + k*W +: W] <= node_d;
        end
      end
    end
  end

  assign bus.o_data  = tree_q[OUT_BASE +: OUTPUT_DATA_WIDTH];
  assign bus.o_valid = vld_q[ADDER_LAYERS];

endmodule

// File: tb/tb_macc_unit.sv
// tb_macc_unit: directed and random checks of macc_unit built with
// NUM_INPUTS = 8, 5 and 1, all driven from the same operand stream
// (the narrower builds see the low elements only).
module tb_macc_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  macc_if #(.NUM_INPUTS(8)) bus8 ();
  macc_if #(.NUM_INPUTS(5)) bus5 ();
  macc_if #(.NUM_INPUTS(1)) bus1 ();

  macc_unit #(.NUM_INPUTS(8)) u_n8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  macc_unit #(.NUM_INPUTS(5)) u_n5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
  macc_unit #(.NUM_INPUTS(1)) u_n1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    int          e8;
    int          e5;
    int          e1;
  } vec_t;

  vec_t tbl [8];

  logic [63:0] ra [20];
  logic [63:0] rb [20];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic v);
    bus8.i_data_a = a;        bus8.i_data_b = b;        bus8.i_valid = v;
    bus5.i_data_a = a[39:0];  bus5.i_data_b = b[39:0];  bus5.i_valid = v;
    bus1.i_data_a = a[7:0];   bus1.i_data_b = b[7:0];   bus1.i_valid = v;
  endtask

  function automatic int dot(input logic [63:0] a, input logic [63:0] b, input int n);
    int s;
    int pa;
    int pb;
    s = 0;
    for (int k = 0; k < n; k++) begin
      pa = $signed(a[8*k +: 8]);
      pb = $signed(b[8*k +: 8]);
      s += pa * pb;
    end
    return s;
  endfunction

  task automatic check_outputs(input string tag, input bit v8, input int e8,
                               input bit v5, input int e5, input bit v1, input int e1);
    check({tag, "_n8_valid"}, 32'(bus8.o_valid), 32'(v8));
    check({tag, "_n5_valid"}, 32'(bus5.o_valid), 32'(v5));
    check({tag, "_n1_valid"}, 32'(bus1.o_valid), 32'(v1));
    if (v8) check({tag, "_n8_data"}, 32'($signed(bus8.o_data)), e8);
    if (v5) check({tag, "_n5_data"}, 32'($signed(bus5.o_data)), e5);
    if (v1) check({tag, "_n1_data"}, 32'($signed(bus1.o_data)), e1);
  endtask

  initial begin
    // Element k occupies byte k (byte 0 is the least significant).
    tbl[0] = '{64'h0101010101010101, 64'h0101010101010101,       8,      5,      1};
    tbl[1] = '{64'hFB05FB05FB05FB05, 64'h0202020202020202,       0,     10,     10};
    tbl[2] = '{64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F,  129032,  80645,  16129};
    tbl[3] = '{64'h8080808080808080, 64'h0101010101010101,   -1024,   -640,   -128};
    tbl[4] = '{64'h8080808080808080, 64'h8080808080808080,  131072,  81920,  16384};
    tbl[5] = '{64'hF807FA05FC03FE01, 64'h0807060504030201,     -36,     15,      1};
    tbl[6] = '{64'h7F7F7F7F7F7F7F7F, 64'h8080808080808080, -130048, -81280, -16256};
    tbl[7] = '{64'h0A0A0A6400000000, 64'h0A0A0AFD00000000,       0,   -300,      0};

    // Reset state.
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    #12;
    check_outputs("reset", 1'b0, 0, 1'b0, 0, 1'b0, 0);
    check("reset_n8_data", 32'($signed(bus8.o_data)), 0);
    check("reset_n1_data", 32'($signed(bus1.o_data)), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors: o_valid must pulse exactly at the latency.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(tbl[i].a, tbl[i].b, 1'b1);
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (c == 1) drive('0, '0, 1'b0);
        check_outputs($sformatf("vec%0d_c%0d", i, c),
                      c == 4, tbl[i].e8, c == 4, tbl[i].e5, c == 1, tbl[i].e1);
      end
    end

    // 20 back-to-back random vectors.
    for (int i = 0; i < 20; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom};
    end
    @(negedge clk);
    drive(ra[0], rb[0], 1'b1);
    for (int j = 0; j < 25; j++) begin
      int i8;
      int i1;
      bit v8;
      bit v1;
      @(posedge clk);
      @(negedge clk);
      i8 = j - 3;
      i1 = j;
      v8 = (i8 >= 0) && (i8 < 20);
      v1 = (i1 >= 0) && (i1 < 20);
      check_outputs($sformatf("rnd_j%0d", j),
                    v8, v8 ? dot(ra[i8], rb[i8], 8) : 0,
                    v8, v8 ? dot(ra[i8], rb[i8], 5) : 0,
                    v1, v1 ? dot(ra[i1], rb[i1], 1) : 0);
      if (j + 1 < 20) drive(ra[j+1], rb[j+1], 1'b1);
      else            drive('0, '0, 1'b0);
    end

    // Reset two cycles after a valid input: in-flight vector is discarded.
    @(negedge clk);
    drive(64'h0303030303030303, 64'h0303030303030303, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive('0, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs("midrst", 1'b0, 0, 1'b0, 0, 1'b0, 0);
    check("midrst_n8_data", 32'($signed(bus8.o_data)), 0);
    check("midrst_n5_data", 32'($signed(bus5.o_data)), 0);
    check("midrst_n1_data", 32'($signed(bus1.o_data)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("postrst_c%0d", c), 1'b0, 0, 1'b0, 0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
